// File: rtl/uv_dbg_arb_pkg.sv
// Shared types and constants for the two-master debug port arbiter.
package uv_dbg_arb_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } arb_state_e;

  localparam logic [1:0] DBG_EXCP_OK  = 2'b00;
  localparam logic [1:0] DBG_EXCP_TMO = 2'b11;

endpackage

// File: rtl/uv_dbg_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to prio.
module uv_dbg_rr2 (
  input  logic [1:0] vld,
  input  logic       prio,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    case (vld)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = prio;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/uv_dbg_arb.sv
// Shares the single debug access port between m0 (JTAG DTM) and m1 (system-bus master),
// one transaction outstanding, with a synthesized error response on slave timeout.
module uv_dbg_arb
  import uv_dbg_arb_pkg::*;
#(
  parameter int ALEN    = 12,
  parameter int DLEN    = 32,
  parameter int MLEN    = DLEN / 8,
  parameter int TMO_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req_vld,
  output logic            m0_req_rdy,
  input  logic            m0_req_read,
  input  logic [ALEN-1:0] m0_req_addr,
  input  logic [MLEN-1:0] m0_req_mask,
  input  logic [DLEN-1:0] m0_req_data,
  output logic            m0_rsp_vld,
  input  logic            m0_rsp_rdy,
  output logic [1:0]      m0_rsp_excp,
  output logic [DLEN-1:0] m0_rsp_data,
  input  logic            m1_req_vld,
  output logic            m1_req_rdy,
  input  logic            m1_req_read,
  input  logic [ALEN-1:0] m1_req_addr,
  input  logic [MLEN-1:0] m1_req_mask,
  input  logic [DLEN-1:0] m1_req_data,
  output logic            m1_rsp_vld,
  input  logic            m1_rsp_rdy,
  output logic [1:0]      m1_rsp_excp,
  output logic [DLEN-1:0] m1_rsp_data,
  output logic            dbg_req_vld,
  input  logic            dbg_req_rdy,
  output logic            dbg_req_read,
  output logic [ALEN-1:0] dbg_req_addr,
  output logic [MLEN-1:0] dbg_req_mask,
  output logic [DLEN-1:0] dbg_req_data,
  input  logic            dbg_rsp_vld,
  output logic            dbg_rsp_rdy,
  input  logic [1:0]      dbg_rsp_excp,
  input  logic [DLEN-1:0] dbg_rsp_data,
  output logic            arb_drop
);

  localparam int TW = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  arb_state_e    state;
  logic          owner;
  logic          prio;
  logic [TW-1:0] tmo_cnt;
  logic          rsp_tmo;
  logic          drop_r;

  logic            gnt;
  logic            idle;
  logic            own_rsp_rdy;
  logic            rsp_vld_int;
  logic            req_hs;
  logic            rsp_hs;
  logic [1:0]      rsp_excp_int;
  logic [DLEN-1:0] rsp_data_int;

  uv_dbg_rr2 u_rr2 (
    .vld  ({m1_req_vld, m0_req_vld}),
    .prio (prio),
    .gnt  (gnt)
  );

  assign idle = (state == ST_IDLE);

  assign dbg_req_vld  = idle & (m0_req_vld | m1_req_vld);
  assign dbg_req_read = gnt ? m1_req_read : m0_req_read;
  assign dbg_req_addr = gnt ? m1_req_addr : m0_req_addr;
  assign dbg_req_mask = gnt ? m1_req_mask : m0_req_mask;
  assign dbg_req_data = gnt ? m1_req_data : m0_req_data;

  assign m0_req_rdy = idle & ~gnt & m0_req_vld & dbg_req_rdy;
  assign m1_req_rdy = idle &  gnt & m1_req_vld & dbg_req_rdy;
  assign req_hs     = dbg_req_vld & dbg_req_rdy;

  // Once the timeout response is raised the port is blocked so a late answer cannot alias it.
  assign own_rsp_rdy  = owner ? m1_rsp_rdy : m0_rsp_rdy;
  assign rsp_vld_int  = ~idle & (dbg_rsp_vld | rsp_tmo);
  assign rsp_excp_int = rsp_tmo ? DBG_EXCP_TMO : dbg_rsp_excp;
  assign rsp_data_int = rsp_tmo ? '0 : dbg_rsp_data;
  assign rsp_hs       = rsp_vld_int & own_rsp_rdy;
  assign dbg_rsp_rdy  = idle | (own_rsp_rdy & ~rsp_tmo);

  assign m0_rsp_vld  = rsp_vld_int & ~owner;
  assign m1_rsp_vld  = rsp_vld_int &  owner;
  assign m0_rsp_excp = m0_rsp_vld ? rsp_excp_int : DBG_EXCP_OK;
  assign m1_rsp_excp = m1_rsp_vld ? rsp_excp_int : DBG_EXCP_OK;
  assign m0_rsp_data = m0_rsp_vld ? rsp_data_int : '0;
  assign m1_rsp_data = m1_rsp_vld ? rsp_data_int : '0;

  assign arb_drop = drop_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      prio    <= 1'b0;
      tmo_cnt <= '0;
      rsp_tmo <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      drop_r <= idle & dbg_rsp_vld;
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            state   <= ST_WAIT_RSP;
            owner   <= gnt;
            prio    <= ~gnt;
            tmo_cnt <= '0;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_hs) begin
            state   <= ST_IDLE;
            rsp_tmo <= 1'b0;
          end else if (!rsp_tmo && !dbg_rsp_vld) begin
            // A pending port response freezes the count, so it always beats the timeout.
            if (tmo_cnt == TMO_LAST) rsp_tmo <= 1'b1;
            else                     tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
